blackbox_sweep_ctrl: RTL



---
 rtl/blackbox_pkg.sv | 14 +
 rtl/blackbox_settle_timer.sv | 29 ++
 rtl/blackbox_sweep_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/blackbox_pkg.sv
// Shared types and sizes for the blackbox truth-table sweep controller.
package blackbox_pkg;

   localparam int N_IN = 3;
   localparam int TT_W = 2 ** N_IN;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/blackbox_settle_timer.sv
// Settle-time counter: clear has priority over enable; expire flags the last settle cycle.
module blackbox_settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CNT_W = $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_expire = (r_cnt == CNT_LAST);

endmodule

// File: rtl/blackbox_sweep_ctrl.sv
// Walks the blackbox through every input vector, captures its truth table and
// compares it with the golden table supplied by the host.
module blackbox_sweep_ctrl
   import blackbox_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_abort,
   input  logic            i_bb_out,
   input  logic [TT_W-1:0] i_expected,
   output logic            o_drive_i,
   output logic            o_drive_h,
   output logic            o_drive_o,
   output logic            o_busy,
   output logic            o_done,
   output logic [TT_W-1:0] o_truth_table,
   output logic            o_table_valid,
   output logic            o_match
);

   localparam logic [N_IN-1:0] VEC_LAST = N_IN'(TT_W - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [N_IN-1:0]   r_vec;
   logic [TT_W-1:0]   r_tt;
   logic              r_valid;
   logic              r_match;
   logic              w_timer_clr;
   logic              w_timer_en;
   logic              w_expire;
   logic              w_start_ok;

   // abort beats start when both arrive together in IDLE
   assign w_start_ok = i_start && !i_abort;

   blackbox_settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_timer_clr),
      .i_en     (w_timer_en),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_timer_clr  = 1'b0;
      w_timer_en   = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_state_next = S_SETTLE;
               w_timer_clr  = 1'b1;
            end
         end
         S_SETTLE: begin
            o_busy = 1'b1;
            if (i_abort) begin
               w_state_next = S_IDLE;
               w_timer_clr  = 1'b1;
            end else if (w_expire) begin
               w_state_next = S_SAMPLE;
               w_timer_clr  = 1'b1;
            end else begin
               w_timer_en = 1'b1;
            end
         end
         S_SAMPLE: begin
            o_busy = 1'b1;
            if (i_abort) begin
               w_state_next = S_IDLE;
               w_timer_clr  = 1'b1;
            end else if (r_vec == VEC_LAST) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_SETTLE;
            end
         end
         S_DONE: begin
            o_done       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec   <= '0;
         r_tt    <= '0;
         r_valid <= 1'b0;
         r_match <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_vec   <= '0;
                  r_tt    <= '0;
                  r_valid <= 1'b0;
                  r_match <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (i_abort) begin
                  r_vec   <= '0;
                  r_valid <= 1'b0;
                  r_match <= 1'b0;
               end
            end
            S_SAMPLE: begin
               if (i_abort) begin
                  r_vec   <= '0;
                  r_valid <= 1'b0;
                  r_match <= 1'b0;
               end else begin
                  r_tt[r_vec] <= i_bb_out;
                  if (r_vec != VEC_LAST) begin
                     r_vec <= r_vec + N_IN'(1);
                  end
               end
            end
            S_DONE: begin
               // the last sample landed on the edge that entered DONE
               r_valid <= 1'b1;
               r_match <= (r_tt == i_expected);
               r_vec   <= '0;
            end
            default: begin
               r_vec <= '0;
            end
         endcase
      end
   end

   assign o_drive_i     = r_vec[2];
   assign o_drive_h     = r_vec[1];
   assign o_drive_o     = r_vec[0];
   assign o_truth_table = r_tt;
   assign o_table_valid = r_valid;
   assign o_match       = r_match;

endmodule
